alu_wb: RTL
===========

Name: alu_wb

Overview:
- Execute/writeback stage that sits directly downstream of the register file.
- Consumes the accumulator (R0) and the selected operand register, computes the result, and drives the register file write port (dat_in / wr_en / wr_addr).
- Single-cycle ops finish one cycle after start. MUL (and optional DIV) iterate and stall the front end through busy.

Parameters:
- pw, 4: register address pointer width; the address bus is pw+1 bits, matching the register file write port.
- MUL_ITERS, 8: iteration count for the shift-add multiplier (and the divider).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue pulse; sampled only while busy=0.
- op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 SHL, 5 SHR, 6 MUL, 7 DIV.
- dst  in  pw+1  destination register address.
- acc_in  in  8  R0 value from the register file acc_out.
- opA_in  in  8  operand from the register file datA_out.
- busy  out  1  high from the cycle after start until the done cycle, inclusive.
- done  out  1  one-cycle pulse on the final write (or final cycle) of an op.
- wr_en  out  1  register file write enable.
- wr_addr  out  pw+1  register file write address.
- wr_dat  out  8  register file write data.
- carry  out  1  carry/borrow flag.
- zero  out  1  high when the last written result byte is 0.

Behaviour:
- Reset: state IDLE; busy, done, wr_en, carry and zero = 0; wr_addr = 0; wr_dat = 0; operand and product registers cleared.
- Operand capture:
  - On start while IDLE, register acc_in, opA_in, op and dst.
  - Later changes on the inputs do not affect the op in flight.
  - start while busy=1 is ignored (no queueing).
- Single-cycle ops (ADD, SUB, AND, XOR, SHL, SHR):
  - State EXEC for one cycle after start: wr_en=1, wr_addr=dst, done=1, busy=1.
  - Then IDLE.
  - Latency: start at cycle N, write at cycle N+1.
- Arithmetic:
  - ADD: 9-bit sum; wr_dat = low 8 bits; carry = bit 8.
  - SUB: acc minus opA modulo 256; carry = 1 when acc >= opA (no borrow).
  - SHL: acc<<1 with zero fill; carry = acc[7].
  - SHR: logical acc>>1; carry = acc[0].
  - AND, XOR: carry unchanged.
- zero updates on every write from wr_dat. carry holds between ops.
- MUL (8x8 unsigned, 16-bit product):
  - IDLE -> MITER for MUL_ITERS cycles, one shift-add step per cycle, using an iteration counter 0..MUL_ITERS-1.
  - Then WR_LO: wr_en=1, wr_addr=dst, wr_dat=product[7:0].
  - Then WR_HI: wr_en=1, wr_addr=0, wr_dat=product[15:8], done=1.
  - Then IDLE.
  - Latency: start at N; writes at N+9 and N+10.
  - carry = 1 when product[15:8] != 0.
  - If dst=0, the WR_HI write overwrites WR_LO; R0 ends holding the high byte.
- DIV: see Optional Feature.
- wr_en is never asserted in IDLE or MITER.
- wr_addr and wr_dat hold their last values when wr_en=0.
- reset mid-op: next state IDLE, any pending write dropped, flags cleared.
- start and reset in the same cycle: reset wins.
- A new start is accepted in the cycle after done (back-to-back issue).

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined:
  - op 7 is restoring unsigned division acc / opA over MUL_ITERS cycles, reusing the MITER state and counter.
  - WR_LO writes the quotient to dst; WR_HI writes the remainder to R0.
  - Divide by zero: quotient 0xFF, remainder = acc, carry=1; same latency.
- Undefined:
  - op 7 behaves as a NOP: one EXEC cycle, done=1, wr_en=0, flags unchanged.

Decomposition:
- Package alu_pkg holds:
  - op_t enum for the 3-bit opcodes.
  - state_t enum: IDLE, EXEC, MITER, WR_LO, WR_HI.
  - constant ACC_ADDR = 0.
- Sub-module iter_muldiv: iterative shift-add/restoring datapath with load, step, mode and 16-bit result.
- alu_wb holds the FSM, the single-cycle ops, the flags and the write port.

Test Plan:
- Reset, then ADD with acc=0xF0, opA=0x20, dst=3: next cycle wr_en=1, wr_addr=3, wr_dat=0x10, carry=1, zero=0, done=1.
- SUB with acc=0x05, opA=0x05, dst=2: wr_dat=0x00, zero=1, carry=1. Then SUB with acc=0x03, opA=0x05: wr_dat=0xFE, carry=0.
- MUL with acc=0xC8, opA=0x0A, dst=5:
  - busy for 10 cycles.
  - Cycle N+9: write R5=0xD0.
  - Cycle N+10: write R0=0x07, done=1, carry=1.
  - start pulses during busy produce no extra writes.
- reset asserted at iteration 4 of a MUL: next cycle IDLE, busy=0, no writes follow. A new ADD issued afterwards completes normally.
- Back-to-back issue: XOR (acc=0xAA, opA=0xFF) immediately after SHR (acc=0x81) gives writes 0x40 (carry=1), then 0x55 on consecutive ops with no lost start.
- op 7 with acc=0x64, opA=0x07:
  - With ALU_DIV_EN: quotient 0x0E to dst, remainder 0x02 to R0.
  - Without ALU_DIV_EN: done pulse only, wr_en=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state encodings for the alu_wb execute/writeback stage.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_SHL = 3'd4,
        OP_SHR = 3'd5,
        OP_MUL = 3'd6,
        OP_DIV = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        MITER = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4
    } state_t;

    localparam int ACC_ADDR = 0;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative 8x8 shift-add multiplier / restoring divider sharing one 16-bit
// register: {hi, lo} = {product high, product low} or {remainder, quotient}.
module iter_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        mode,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] result
);

    logic [15:0] p_q, p_d;
    logic [7:0]  b_q, b_d;
    logic [8:0]  add_sum;
    logic [16:0] sh;
    logic [8:0]  trial;

    always_comb begin
        p_d     = p_q;
        b_d     = b_q;
        add_sum = {1'b0, p_q[15:8]} + (p_q[0] ? {1'b0, b_q} : 9'd0);
        sh      = {p_q, 1'b0};
        trial   = sh[16:8] - {1'b0, b_q};
        if (load) begin
            p_d = {8'd0, a};
            b_d = b;
        end else if (step) begin
            // trial[8] set means the subtraction borrowed: restore
            if (mode) begin
                p_d = trial[8] ? sh[15:0] : {trial[7:0], sh[7:1], 1'b1};
            end else begin
                p_d = {add_sum, p_q[7:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q <= '0;
            b_q <= '0;
        end else begin
            p_q <= p_d;
            b_q <= b_d;
        end
    end

    assign result = p_q;

endmodule

// File: rtl/alu_wb.sv
// Execute/writeback stage driving the register file write port.
// Define ALU_DIV_EN to enable op 7 as iterative divide (otherwise a NOP).
module alu_wb
    import alu_pkg::*;
#(
    parameter int pw        = 4,
    parameter int MUL_ITERS = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [pw:0]   dst,
    input  logic [7:0]    acc_in,
    input  logic [7:0]    opA_in,
    output logic          busy,
    output logic          done,
    output logic          wr_en,
    output logic [pw:0]   wr_addr,
    output logic [7:0]    wr_dat,
    output logic          carry,
    output logic          zero
);

`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam int CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_ITERS - 1);
    localparam logic [pw:0] R0 = (pw + 1)'(ACC_ADDR);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  opa_q, opa_d;
    logic [pw:0] dst_q, dst_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [pw:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_dat_q, wr_dat_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic        wr_en_d, done_d;
    logic        md_load, md_step, md_mode, is_div, it_carry;
    logic [8:0]  sum;
    logic [15:0] md_res;

    iter_muldiv u_md (
        .clk    (clk),
        .reset  (reset),
        .load   (md_load),
        .step   (md_step),
        .mode   (md_mode),
        .a      (acc_in),
        .b      (opA_in),
        .result (md_res)
    );

    assign is_div  = DIV_EN && (op_q == OP_DIV);
    assign md_mode = is_div;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        md_load = 1'b0;
        md_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_t'(op);
                    acc_d   = acc_in;
                    opa_d   = opA_in;
                    dst_d   = dst;
                    cnt_d   = '0;
                    md_load = 1'b1;
                    if (op_t'(op) == OP_MUL ||
                        (DIV_EN && op_t'(op) == OP_DIV)) begin
                        state_d = MITER;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC:  state_d = IDLE;
            MITER: begin
                md_step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = WR_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_LO: state_d = WR_HI;
            WR_HI: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write port and flags are decoded from state; the _q copies hold the
    // last written values between writes.
    always_comb begin
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        sum       = {1'b0, acc_q} + {1'b0, opa_q};
        it_carry  = is_div ? (opa_q == 8'd0) : (md_res[15:8] != 8'd0);
        unique case (state_q)
            EXEC: begin
                done_d    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = dst_q;
                unique case (op_q)
                    OP_ADD: {carry_d, wr_dat_d} = sum;
                    OP_SUB: begin
                        wr_dat_d = acc_q - opa_q;
                        carry_d  = acc_q >= opa_q;
                    end
                    OP_AND: wr_dat_d = acc_q & opa_q;
                    OP_XOR: wr_dat_d = acc_q ^ opa_q;
                    OP_SHL: {carry_d, wr_dat_d} = {acc_q, 1'b0};
                    OP_SHR: {wr_dat_d, carry_d} = {1'b0, acc_q};
                    default: begin
                        wr_en_d   = 1'b0;
                        wr_addr_d = wr_addr_q;
                    end
                endcase
            end
            WR_LO: begin
                wr_en_d   = 1'b1;
                wr_addr_d = dst_q;
                wr_dat_d  = md_res[7:0];
                carry_d   = it_carry;
            end
            WR_HI: begin
                wr_en_d   = 1'b1;
                done_d    = 1'b1;
                wr_addr_d = R0;
                wr_dat_d  = md_res[15:8];
                carry_d   = it_carry;
            end
            default: ;
        endcase
        if (wr_en_d) begin
            zero_d = (wr_dat_d == 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_ADD;
            acc_q     <= '0;
            opa_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_d;
    assign wr_en   = wr_en_d;
    assign wr_addr = wr_addr_d;
    assign wr_dat  = wr_dat_d;
    assign carry   = carry_d;
    assign zero    = zero_d;

endmodule
